// File: rtl/loba_iter.sv
// loba_iter: iterative approximate unsigned multiplier.
// Each operand is split into up to S leading-one-anchored K-bit segments.
// The segment cross-products with i+j < L are summed, one term per cycle.
module loba_iter #(
    parameter int N = 16,
    parameter int K = 4,
    parameter int S = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [2:0]     lvl,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    // KW holds any shift amount up to 2*(N-K).
    // IW indexes the S segments.
    localparam int KW = $clog2(N) + 1;
    localparam int IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {IDLE, SPLIT, ACC, DONE} state_t;

    state_t                  state;
    logic [N-1:0]            a_reg;
    logic [N-1:0]            b_reg;
    logic [2:0]              l_reg;
    logic [S-1:0][K-1:0]     xa;
    logic [S-1:0][K-1:0]     xb;
    logic [S-1:0][KW-1:0]    ka;
    logic [S-1:0][KW-1:0]    kb;
    logic [2*N-1:0]          acc;
    logic [IW-1:0]           ti;
    logic [IW-1:0]           td;

    logic [S-1:0][K-1:0]     xa_c;
    logic [S-1:0][K-1:0]     xb_c;
    logic [S-1:0][KW-1:0]    ka_c;
    logic [S-1:0][KW-1:0]    kb_c;
    logic [2:0]              l_clamped;
    logic [IW-1:0]           tj;
    logic [KW-1:0]           sh_amt;
    logic [2*N-1:0]          term;
    logic                    last_term;

    // One segment step.
    // Take the K bits below and including the leading one, then clear them from the residual.
    // A residual narrower than K is taken whole, and nothing remains after it.
    function automatic logic [N+K+KW-1:0] seg_step(input logic [N-1:0] r);
        logic [N-1:0]  mask;
        logic [N-1:0]  rn;
        logic [K-1:0]  x;
        logic [KW-1:0] k;
        int            q;
        q = -1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) q = i;
        end
        mask = '0;
        mask[K-1:0] = '1;
        rn = '0;
        x = '0;
        k = '0;
        if (q >= K - 1) begin
            x  = K'(r >> (q - K + 1));
            k  = KW'(q - K + 1);
            rn = r & ~(mask << (q - K + 1));
        end else if (q >= 0) begin
            x = r[K-1:0];
        end
        return {rn, x, k};
    endfunction

    assign in_ready = (state == IDLE) && rst_n;

    // Clamp the requested level into 1..S.
    always_comb begin
        l_clamped = lvl;
        if (lvl == 3'd0) begin
            l_clamped = 3'd1;
        end else if (lvl > 3'(S)) begin
            l_clamped = 3'(S);
        end
    end

    // Split both registered operands into S segments, chaining each residual into the next step.
    always_comb begin : split_blk
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        ra = a_reg;
        rb = b_reg;
        xa_c = '0;
        xb_c = '0;
        ka_c = '0;
        kb_c = '0;
        for (int j = 0; j < S; j++) begin
            {ra, xa_c[j], ka_c[j]} = seg_step(ra);
            {rb, xb_c[j], kb_c[j]} = seg_step(rb);
        end
    end

    // Current term (ti, td-ti), computed at full product width, and the end-of-walk flag.
    always_comb begin
        tj        = td - ti;
        sh_amt    = ka[ti] + kb[tj];
        term      = ({{(2*N-K){1'b0}}, xa[ti]} * {{(2*N-K){1'b0}}, xb[tj]}) << sh_amt;
        last_term = (ti == td) && (3'(td) == (l_reg - 3'd1));
    end

    // Control FSM and datapath.
    // The terms are walked diagonal by diagonal (td = i+j), with i rising inside each diagonal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            l_reg     <= '0;
            xa        <= '0;
            xb        <= '0;
            ka        <= '0;
            kb        <= '0;
            acc       <= '0;
            ti        <= '0;
            td        <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        l_reg <= l_clamped;
                        acc   <= '0;
                        ti    <= '0;
                        td    <= '0;
                        busy  <= 1'b1;
                        state <= SPLIT;
                    end
                end
                SPLIT: begin
                    xa    <= xa_c;
                    xb    <= xb_c;
                    ka    <= ka_c;
                    kb    <= kb_c;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc + term;
                    if (last_term) begin
                        p         <= acc + term;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (ti == td) begin
                        ti <= '0;
                        td <= td + 1'b1;
                    end else begin
                        ti <= ti + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loba_iter.sv
// tb_loba_iter: directed test of loba_iter with N=16, K=4, S=2.
// The expected products are worked out by hand from the segment rules.
module tb_loba_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  lvl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int compared;
    int mismatched;
    int lat;
    logic [31:0] held_p;

    loba_iter #(.N(16), .K(4), .S(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .lvl       (lvl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    // A mismatch is counted and reported.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge.
    // After that edge, in_valid drops and the operand inputs are scrambled.
    task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] il);
        checkOutput("ready_before_req", 64'(in_ready), 64'd1);
        a = ia;
        b = ib;
        lvl = il;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lvl = 3'($urandom);
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Wait, within a bounded number of edges, for out_valid.
    // Then check the latency and the product.
    // When hold is set, in_valid stays high and the operand inputs change on every cycle.
    task automatic waitResult(input string tag, input logic [31:0] exp_p, input int exp_lat, input bit hold);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (hold) begin
                in_valid = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
                lvl = 3'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_p"}, 64'(p), 64'(exp_p));
    endtask

    // Consume the result.
    // The block must be back in IDLE right after the handshake edge.
    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checkOutput({tag, "_valid_cleared"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_busy_cleared"}, 64'(busy), 64'd0);
        checkOutput({tag, "_ready_again"}, 64'(in_ready), 64'd1);
    endtask

    // Directed sequence.
    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        lvl = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_p", 64'(p), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_ready", 64'(in_ready), 64'd1);

        // 0xFF x 0xFF with L=2: 0xE100 + 2*0xE10
        applyStimulus(16'h00FF, 16'h00FF, 3'd2);
        waitResult("ff_l2", 32'h0000FD20, 4, 1'b0);
        releaseResult("ff_l2");

        // 0xFF x 0xFF with L=1: only the leading term
        applyStimulus(16'h00FF, 16'h00FF, 3'd1);
        waitResult("ff_l1", 32'h0000E100, 2, 1'b0);
        releaseResult("ff_l1");

        // lvl=0 clamps up to L=1
        applyStimulus(16'h00FF, 16'h00FF, 3'd0);
        waitResult("ff_l0", 32'h0000E100, 2, 1'b0);
        releaseResult("ff_l0");

        // lvl=7 clamps down to L=2
        applyStimulus(16'hFFFF, 16'hFFFF, 3'd7);
        waitResult("ffff_l7", 32'hFD200000, 4, 1'b0);
        releaseResult("ffff_l7");

        // narrow operands give the exact product
        applyStimulus(16'h0005, 16'h0003, 3'd2);
        waitResult("five_three", 32'h0000000F, 4, 1'b0);
        releaseResult("five_three");

        // zero operand keeps the full latency
        applyStimulus(16'h0000, 16'h1234, 3'd2);
        waitResult("zero_a", 32'h00000000, 4, 1'b0);
        releaseResult("zero_a");

        // 0x1234 x 0x5678 L=2, with in_valid held and a/b changing while busy
        // terms 9*10<<20 + 9*12<<16 + 13*10<<13
        applyStimulus(16'h1234, 16'h5678, 3'd2);
        waitResult("hold_valid", 32'h061C4000, 4, 1'b1);
        releaseResult("hold_valid");

        // backpressure: five cycles with out_ready low in DONE
        applyStimulus(16'h00FF, 16'h00FF, 3'd2);
        waitResult("stall", 32'h0000FD20, 4, 1'b0);
        held_p = p;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_p", 64'(p), 64'(held_p));
            checkOutput("stall_ready", 64'(in_ready), 64'd0);
        end
        releaseResult("stall");

        // reset in the middle of ACC drops the operation
        applyStimulus(16'h00FF, 16'h00FF, 3'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("midacc_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready_low", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_p", 64'(p), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst_no_output", 64'(out_valid), 64'd0);

        applyStimulus(16'h0005, 16'h0003, 3'd2);
        waitResult("after_rst", 32'h0000000F, 4, 1'b0);
        releaseResult("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
